// File: rtl/timer_ctrl.sv
// timer_ctrl: down-counting timer sequencer (off / one-shot / periodic / PWM) with
// shadow+active config banks. Define TIMER_PRESCALE_EN to include the clock prescaler.
module timer_ctrl #(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr,
    input  logic [1:0]            cfg_mode,
    input  logic [WIDTH-1:0]      cfg_reload,
    input  logic [WIDTH-1:0]      cfg_compare,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  irq_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  expire,
    output logic                  irq,
    output logic                  pwm_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_PWM      = 2'b11
    } mode_t;

    typedef struct packed {
        mode_t            mode;
        logic [WIDTH-1:0] reload;
        logic [WIDTH-1:0] compare;
    } cfg_t;

    state_t state;
    cfg_t   shadow;
    cfg_t   active;
    logic   tick;
    logic   start_ok;
    logic   wrap;
    logic   load_active;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // stop beats start; an unconfigured (off or zero-reload) timer never starts.
    assign start_ok = start && !stop && (active.mode != MODE_OFF) && (active.reload != '0);

    assign wrap        = (state == RUN) && !stop && tick && (count == '0)
                         && (active.mode != MODE_ONESHOT);
    assign load_active = (state != RUN) || wrap;

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] shadow_prescale;
    logic [PRESCALE_W-1:0] active_prescale;
    logic [PRESCALE_W-1:0] psc;

    assign tick = (psc == active_prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_prescale <= '0;
            active_prescale <= '0;
            psc             <= '0;
        end else begin
            if (cfg_wr)      shadow_prescale <= cfg_prescale;
            if (load_active) active_prescale <= shadow_prescale;
            // Held at zero outside RUN, so every entry into RUN starts a fresh divide.
            psc <= (state == RUN && !tick) ? psc + PRESCALE_W'(1) : '0;
        end
    end
`else
    logic unused_prescale;

    assign tick            = 1'b1;
    assign unused_prescale = ^cfg_prescale;
`endif

    // NOTE: every register here uses <= so all updates see pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            shadow  <= '0;
            active  <= '0;
            expire  <= 1'b0;
            pwm_out <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (cfg_wr) begin
                shadow <= '{mode: mode_t'(cfg_mode), reload: cfg_reload, compare: cfg_compare};
            end
            if (load_active) active <= shadow;
            pwm_out <= (state == RUN) && (active.mode == MODE_PWM) && (count > active.compare);

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state <= RUN;
                        count <= active.reload;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (count != '0) begin
                            count <= count - WIDTH'(1);
                        end else if (active.mode == MODE_ONESHOT) begin
                            state  <= DONE;
                            expire <= 1'b1;
                        end else if (shadow.mode == MODE_OFF) begin
                            // Reprogrammed to off while running: retire quietly at the wrap.
                            state <= IDLE;
                        end else begin
                            count  <= shadow.reload;
                            expire <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (start_ok) begin
                        state <= RUN;
                        count <= active.reload;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Set has priority so an expiry landing on a clear is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       irq <= 1'b0;
        else if (expire)  irq <= 1'b1;
        else if (irq_clr) irq <= 1'b0;
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed scoreboard bench for timer_ctrl: expectations are queued with the stimulus
// and popped against the DUT one negedge after the driving edge.
module tb_timer_ctrl;

    localparam int WIDTH      = 32;
    localparam int PRESCALE_W = 8;
`ifdef TIMER_PRESCALE_EN
    localparam int PSC_EN = 1;
`else
    localparam int PSC_EN = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cfg_wr = 1'b0;
    logic [1:0]            cfg_mode = '0;
    logic [WIDTH-1:0]      cfg_reload = '0;
    logic [WIDTH-1:0]      cfg_compare = '0;
    logic [PRESCALE_W-1:0] cfg_prescale = '0;
    logic                  start = 1'b0;
    logic                  stop = 1'b0;
    logic                  irq_clr = 1'b0;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  done;
    logic                  expire;
    logic                  irq;
    logic                  pwm_out;

    always #5 clk = ~clk;

    timer_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_wr       (cfg_wr),
        .cfg_mode     (cfg_mode),
        .cfg_reload   (cfg_reload),
        .cfg_compare  (cfg_compare),
        .cfg_prescale (cfg_prescale),
        .start        (start),
        .stop         (stop),
        .irq_clr      (irq_clr),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .expire       (expire),
        .irq          (irq),
        .pwm_out      (pwm_out)
    );

    typedef enum {S_COUNT, S_BUSY, S_DONE, S_EXPIRE, S_IRQ, S_PWM} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic int period(input int reload, input int p);
        return (reload + 1) * ((PSC_EN != 0 ? p : 0) + 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            S_COUNT:  return count;
            S_BUSY:   return {31'b0, busy};
            S_DONE:   return {31'b0, done};
            S_EXPIRE: return {31'b0, expire};
            S_IRQ:    return {31'b0, irq};
            default:  return {31'b0, pwm_out};
        endcase
    endfunction

    task automatic want(input string tag, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic flush();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.tag, sample(e.sig), e.val);
        end
    endtask

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush();
    endtask

    task automatic configure(input logic [1:0] m, input logic [31:0] r,
                             input logic [31:0] c, input logic [7:0] p);
        cfg_mode     = m;
        cfg_reload   = r;
        cfg_compare  = c;
        cfg_prescale = p;
        cfg_wr       = 1'b1;
        cycle();
        cfg_wr = 1'b0;
        cycle();
    endtask

    task automatic wait_expire(input int offset, output int n);
        n = offset;
        do begin
            cycle();
            n++;
        end while (expire !== 1'b1 && n < 500);
        if (expire !== 1'b1) n = -1;
    endtask

    task automatic wait_count(input logic [31:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (count === v) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        bit ok;

        // Reset state
        want("rst_count", S_COUNT, 0);
        want("rst_busy", S_BUSY, 0);
        want("rst_done", S_DONE, 0);
        want("rst_expire", S_EXPIRE, 0);
        want("rst_irq", S_IRQ, 0);
        want("rst_pwm", S_PWM, 0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // One-shot, reload 3
        configure(2'b01, 3, 0, 0);
        start = 1'b1;
        want("os_busy", S_BUSY, 1);
        want("os_count3", S_COUNT, 3);
        cycle();
        start = 1'b0;
        for (int v = 2; v >= 0; v--) begin
            want($sformatf("os_count%0d", v), S_COUNT, v);
            want("os_no_expire", S_EXPIRE, 0);
            cycle();
        end
        want("os_expire", S_EXPIRE, 1);
        want("os_done", S_DONE, 1);
        want("os_busy_low", S_BUSY, 0);
        want("os_count_hold", S_COUNT, 0);
        cycle();
        want("os_irq", S_IRQ, 1);
        want("os_expire_pulse", S_EXPIRE, 0);
        want("os_done_hold", S_DONE, 1);
        cycle();
        irq_clr = 1'b1;
        want("os_irq_clr", S_IRQ, 0);
        cycle();
        irq_clr = 1'b0;
        stop = 1'b1;
        want("os_stop_done", S_DONE, 0);
        want("os_stop_busy", S_BUSY, 0);
        cycle();
        stop = 1'b0;

        // Periodic reload 4, prescale 1, then mid-run reload change to 2
        configure(2'b10, 4, 0, 1);
        start = 1'b1;
        want("per_busy", S_BUSY, 1);
        want("per_count", S_COUNT, 4);
        cycle();
        start = 1'b0;
        wait_expire(0, n);
        check("per_first_period", n, period(4, 1));
        check("per_wrap_count", count, 4);
        want("per_irq", S_IRQ, 1);
        cycle();
        irq_clr = 1'b1;
        want("per_irq_clr", S_IRQ, 0);
        cycle();
        irq_clr = 1'b0;
        cfg_mode = 2'b10; cfg_reload = 2; cfg_compare = 0; cfg_prescale = 1;
        cfg_wr = 1'b1;
        cycle();
        cfg_wr = 1'b0;
        wait_expire(3, n);
        check("per_old_period", n, period(4, 1));
        irq_clr = 1'b1;
        want("irq_set_wins", S_IRQ, 1);
        cycle();
        irq_clr = 1'b0;
        wait_expire(1, n);
        check("per_new_period", n, period(2, 1));
        check("per_new_reload", count, 2);

        // Stop at count 2 holds the value
        stop = 1'b1;
        want("stop_busy", S_BUSY, 0);
        want("stop_count", S_COUNT, 2);
        cycle();
        stop = 1'b0;
        want("stop_hold_count", S_COUNT, 2);
        want("stop_hold_busy", S_BUSY, 0);
        want("stop_no_expire", S_EXPIRE, 0);
        cycle(3);
        irq_clr = 1'b1;
        want("stop_irq_clr", S_IRQ, 0);
        cycle();
        irq_clr = 1'b0;

        // Start with reload 0 is ignored
        configure(2'b10, 0, 0, 0);
        start = 1'b1;
        want("rl0_busy", S_BUSY, 0);
        want("rl0_count", S_COUNT, 2);
        cycle();
        start = 1'b0;

        // Start and stop together in IDLE: stop wins
        configure(2'b10, 5, 0, 0);
        start = 1'b1;
        stop  = 1'b1;
        want("ss_busy", S_BUSY, 0);
        want("ss_count", S_COUNT, 2);
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        want("ss_busy_after", S_BUSY, 0);
        cycle();

        // Prescale 7: period depends on whether the prescaler is built in
        configure(2'b10, 2, 0, 7);
        start = 1'b1;
        want("psc_busy", S_BUSY, 1);
        cycle();
        start = 1'b0;
        wait_expire(0, n);
        check("psc_period", n, period(2, 7));
        stop = 1'b1;
        want("psc_stop", S_BUSY, 0);
        cycle();
        stop = 1'b0;

        // PWM reload 9, compare 4: five high, five low, period 10
        configure(2'b11, 9, 4, 0);
        start = 1'b1;
        for (int k = 0; k < 25; k++) begin
            want($sformatf("pwm_count_k%0d", k), S_COUNT, 9 - (k % 10));
            want($sformatf("pwm_out_k%0d", k), S_PWM,
                 (k == 0) ? 0 : (((9 - ((k - 1) % 10)) > 4) ? 1 : 0));
            want($sformatf("pwm_expire_k%0d", k), S_EXPIRE, (k > 0 && k % 10 == 0) ? 1 : 0);
            cycle();
            start = 1'b0;
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // PWM compare == reload: constant low
        configure(2'b11, 9, 9, 0);
        start = 1'b1;
        for (int k = 0; k < 25; k++) begin
            want($sformatf("pwm_flat_k%0d", k), S_PWM, 0);
            cycle();
            start = 1'b0;
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // Mid-run switch to off: IDLE at the next wrap, no expire
        configure(2'b10, 3, 0, 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_expire(0, n);
        check("off_first_period", n, period(3, 0));
        cfg_mode = 2'b00; cfg_reload = 3;
        cfg_wr = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            want($sformatf("off_expire_j%0d", j), S_EXPIRE, 0);
            want($sformatf("off_busy_j%0d", j), S_BUSY, (j < 4) ? 1 : 0);
            cycle();
            cfg_wr = 1'b0;
        end
        want("off_idle_expire", S_EXPIRE, 0);
        want("off_idle_busy", S_BUSY, 0);
        cycle(2);

        // Asynchronous reset in mid-run PWM at count 5
        configure(2'b11, 10, 2, 0);
        start = 1'b1;
        want("ar_busy", S_BUSY, 1);
        want("ar_count", S_COUNT, 10);
        cycle();
        start = 1'b0;
        wait_count(5, ok);
        check("ar_reach5", {31'b0, ok}, 1);
        check("ar_pre_irq", {31'b0, irq}, 1);
        check("ar_pre_pwm", {31'b0, pwm_out}, 1);
        rst_n = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_busy_low", {31'b0, busy}, 0);
        check("ar_done", {31'b0, done}, 0);
        check("ar_expire", {31'b0, expire}, 0);
        check("ar_irq", {31'b0, irq}, 0);
        check("ar_pwm", {31'b0, pwm_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        want("ar_post_busy", S_BUSY, 0);
        want("ar_post_count", S_COUNT, 0);
        want("ar_post_expire", S_EXPIRE, 0);
        cycle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the programmable timer. It holds the timer's configuration and runs a down-counter in one of four modes: off, one-shot, periodic or PWM. It produces expiry events, a sticky interrupt and a PWM waveform. It sits between the register interface and the compare stage: it owns the count value the compare stage examines, and it decides when the count loads, reloads, stops and restarts.

## Interface
- WIDTH, 32, counter, reload and compare width
- PRESCALE_W, 8, prescaler divisor width
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_wr  in  1  strobe: capture cfg_mode, cfg_reload, cfg_compare, cfg_prescale into shadow registers
- cfg_mode  in  2  00 off, 01 one-shot, 10 periodic, 11 PWM
- cfg_reload  in  WIDTH  start/reload count value
- cfg_compare  in  WIDTH  PWM duty threshold
- cfg_prescale  in  PRESCALE_W  tick every cfg_prescale+1 clocks
- start  in  1  pulse: begin counting
- stop  in  1  pulse: halt, hold count
- irq_clr  in  1  clear irq
- count  out  WIDTH  current counter value
- busy  out  1  state is RUN
- done  out  1  state is DONE (one-shot finished)
- expire  out  1  one-cycle pulse per expiry
- irq  out  1  sticky interrupt, set by expire
- pwm_out  out  1  PWM waveform

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE. All shadow and active config is 0. count=0, all outputs 0.
- Config has two banks: shadow and active.
  - cfg_wr always loads the shadow bank.
  - In IDLE or DONE, shadow copies to active on the following cycle.
  - In RUN, shadow copies to active only at a reload, i.e. a periodic or PWM wrap.
- IDLE: start with active mode≠00 and reload≠0 → RUN, count←reload. Otherwise start is ignored.
- RUN: count decrements by 1 on each tick. On a tick with count==0:
  - one-shot: → DONE, count holds 0, expire.
  - periodic/PWM: count←reload (newly applied shadow value), expire, stay RUN.
  - If the newly applied mode is 00, go → IDLE instead, with no expire.
- DONE: start → RUN with count←reload. stop → IDLE.
- stop in RUN → IDLE; count holds its value. If start and stop are asserted in the same cycle, stop wins.
- Prescaler:
  - Counter runs only in RUN and clears on entry to RUN.
  - A tick occurs when the prescaler equals active prescale; the prescaler then wraps to 0.
- irq: set by expire, cleared by irq_clr. If both occur in the same cycle, set wins.
- pwm_out: registered.
  - In RUN with PWM mode: 1 while count > compare, else 0.
  - Otherwise 0.
  - compare ≥ reload gives constant 0; compare=0 gives 1 except during the count==0 phase.
- Arithmetic is unsigned WIDTH. Count never underflows, because the reload is taken at 0.

## Timing
- start sampled at edge N: busy=1 and count=reload from N+1.
- With prescale P, the first decrement happens P+1 clocks after entry. One full period is (reload+1)·(P+1) clocks.
- expire is registered: it is high in the cycle after the zero-count tick, coincident with count showing reload (periodic) or done=1 (one-shot).
- irq rises the cycle after expire rises.
- pwm_out lags count by one cycle.
- stop sampled at edge N: busy=0 from N+1; no further decrement.
- Asynchronous reset mid-RUN: immediately IDLE with all outputs 0; the pending expire is lost.

## Configuration
- TIMER_PRESCALE_EN defined: prescaler present as described above.
- TIMER_PRESCALE_EN undefined:
  - Prescaler logic is removed; every clock in RUN is a tick (P≡0).
  - cfg_prescale is ignored.
  - All other behaviour is unchanged.

## Test plan
- One-shot: mode=01, reload=3, P=0, start → count 3,2,1,0. One expire pulse 4 clocks after busy rises; done=1, irq=1, count stays 0. irq_clr → irq=0.
- Periodic: mode=10, reload=4, P=1 → expire every 10 clocks. Mid-run cfg_wr with reload=2 → old period completes, then a 6-clock period.
- PWM: mode=11, reload=9, compare=4, P=0 → pwm_out high 5 clocks, low 5 clocks, period 10. compare=9 → pwm_out constant 0.
- Control edges:
  - start and stop together in IDLE → stays IDLE.
  - stop at count=2 → holds 2, busy=0.
  - start with reload=0 → ignored.
- Mid-run mode change: cfg_wr mode=00 during periodic → IDLE at next wrap with no expire.
- Async reset: rst_n low at count=5 → all outputs 0 at once, state IDLE. With irq_clr and expire in the same cycle → irq stays 1. Without TIMER_PRESCALE_EN, cfg_prescale=7 has no effect on period.
